// File: rtl/powlib_busxbar_if.sv
// powlib_busxbar_if -- bundle of writer/reader bus signals for powlib_busxbar.
//   wrdatas/wraddrs/wrvlds : writer i payload and valid, writer i at slice i
//   wrrdys                 : per-writer ready (word taken when vld & rdy)
//   rddatas/rdaddrs/rdvlds : reader j output register contents and valid
//   rdrdys                 : per-reader ready
//   errcnt/errvld          : saturating unmapped-write count and per-cycle pulse
// master = the side driving the writers and reader readies; slave = crossbar.
interface powlib_busxbar_if #(
  parameter int B_WRS = 3,
  parameter int B_RDS = 4,
  parameter int B_AW  = 16,
  parameter int B_DW  = 32,
  parameter int ERRW  = 8
);
  logic [B_WRS*B_DW-1:0] wrdatas;
  logic [B_WRS*B_AW-1:0] wraddrs;
  logic [B_WRS-1:0]      wrvlds;
  logic [B_WRS-1:0]      wrrdys;
  logic [B_RDS*B_DW-1:0] rddatas;
  logic [B_RDS*B_AW-1:0] rdaddrs;
  logic [B_RDS-1:0]      rdvlds;
  logic [B_RDS-1:0]      rdrdys;
  logic [ERRW-1:0]       errcnt;
  logic                  errvld;

  modport master (
    output wrdatas, wraddrs, wrvlds, rdrdys,
    input  wrrdys, rddatas, rdaddrs, rdvlds, errcnt, errvld
  );
  modport slave (
    input  wrdatas, wraddrs, wrvlds, rdrdys,
    output wrrdys, rddatas, rdaddrs, rdvlds, errcnt, errvld
  );
endinterface

// File: rtl/powlib_busxbar.sv
// powlib_busxbar -- address-decoded writer-to-reader crossbar.
// Each writer's address is matched against per-reader windows (highest reader
// index wins on overlap). Every reader owns one output register and an arbiter
// (fixed priority or round robin) that grants at most one writer per cycle when
// the register can load. Unmapped writes are acked immediately, dropped, and
// counted in a saturating error counter with a one-cycle errvld pulse.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : powlib_busxbar_if.slave (writer/reader handshakes, error outputs)

// One reader lane: arbiter, pointer and output register.
module powlib_busxbar_port #(
  parameter int B_WRS = 3,
  parameter int B_AW  = 16,
  parameter int B_DW  = 32,
  parameter int ARB   = 1,
  parameter int PW    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [B_WRS-1:0]             i_req,
  input  logic [B_WRS-1:0][B_DW-1:0]   i_wrdata,
  input  logic [B_WRS-1:0][B_AW-1:0]   i_wraddr,
  input  logic                         i_rdrdy,
  output logic [B_WRS-1:0]             o_gnt,
  output logic [B_DW-1:0]              o_rddata,
  output logic [B_AW-1:0]              o_rdaddr,
  output logic                         o_rdvld
);
  logic            r_vld;
  logic [B_DW-1:0] r_data;
  logic [B_AW-1:0] r_addr;
  logic [PW-1:0]   r_ptr;
  logic            w_load, w_hit, w_xfer;
  logic [PW-1:0]   w_idx;
  int              w_cand;

  // Register can take a word when empty or being drained this cycle.
  assign w_load = (!r_vld || i_rdrdy) && !rst;

  // Scan order: 0..N-1 for fixed priority, ptr+1.. wrapping for round robin.
  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_cand = 0;
    o_gnt  = '0;
    for (int n = 0; n < B_WRS; n++) begin
      w_cand = (ARB == 0) ? n : (int'(r_ptr) + 1 + n) % B_WRS;
      if (!w_hit && i_req[w_cand]) begin
        w_hit = 1'b1;
        w_idx = PW'(w_cand);
      end
    end
    if (w_load && w_hit) o_gnt[w_idx] = 1'b1;
  end

  assign w_xfer = w_load && w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_addr <= '0;
      r_ptr  <= PW'(B_WRS - 1);
    end else if (w_xfer) begin
      r_vld  <= 1'b1;
      r_data <= i_wrdata[w_idx];
      r_addr <= i_wraddr[w_idx];
      r_ptr  <= w_idx;
    end else if (i_rdrdy) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_rddata = r_data;
  assign o_rdaddr = r_addr;
  assign o_rdvld  = r_vld;
endmodule

module powlib_busxbar #(
  parameter int                      B_WRS   = 3,
  parameter int                      B_RDS   = 4,
  parameter int                      B_AW    = 16,
  parameter int                      B_DW    = 32,
  parameter logic [B_RDS*B_AW-1:0]   B_BASES = {16'h6000, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [B_RDS*B_AW-1:0]   B_SIZES = {4{16'h1FFF}},
  parameter int                      ARB     = 1,
  parameter int                      ERRW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  powlib_busxbar_if.slave    bus
);
  localparam int PW     = (B_WRS > 1) ? $clog2(B_WRS) : 1;
  localparam int ERRMAX = (1 << ERRW) - 1;

  logic [B_WRS-1:0][B_DW-1:0] w_wrdata;
  logic [B_WRS-1:0][B_AW-1:0] w_wraddr;
  logic [B_WRS-1:0][B_RDS-1:0] w_sel;
  logic [B_WRS-1:0]           w_mapped;
  logic [B_RDS-1:0][B_WRS-1:0] w_req, w_gnt;
  logic [B_RDS-1:0][B_DW-1:0] w_rddata;
  logic [B_RDS-1:0][B_AW-1:0] w_rdaddr;
  logic [B_RDS-1:0]           w_rdvld;
  logic [B_WRS-1:0]           w_wrrdy;
  int                         w_nerr, w_errsum;
  logic [ERRW-1:0]            r_errcnt;
  logic                       r_errvld;

  assign w_wrdata = bus.wrdatas;
  assign w_wraddr = bus.wraddrs;

  // Address decode: one-hot reader select per writer; later j overrides.
  always_comb begin
    w_sel    = '0;
    w_mapped = '0;
    for (int i = 0; i < B_WRS; i++) begin
      for (int j = 0; j < B_RDS; j++) begin
        if (w_wraddr[i] >= B_BASES[j*B_AW +: B_AW] &&
            B_AW'(w_wraddr[i] - B_BASES[j*B_AW +: B_AW]) <= B_SIZES[j*B_AW +: B_AW]) begin
          w_sel[i]    = '0;
          w_sel[i][j] = 1'b1;
          w_mapped[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_req = '0;
    for (int j = 0; j < B_RDS; j++)
      for (int i = 0; i < B_WRS; i++)
        w_req[j][i] = bus.wrvlds[i] & w_sel[i][j];
  end

  for (genvar j = 0; j < B_RDS; j++) begin : g_rd
    powlib_busxbar_port #(
      .B_WRS(B_WRS), .B_AW(B_AW), .B_DW(B_DW), .ARB(ARB), .PW(PW)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .i_req    (w_req[j]),
      .i_wrdata (w_wrdata),
      .i_wraddr (w_wraddr),
      .i_rdrdy  (bus.rdrdys[j]),
      .o_gnt    (w_gnt[j]),
      .o_rddata (w_rddata[j]),
      .o_rdaddr (w_rdaddr[j]),
      .o_rdvld  (w_rdvld[j])
    );
  end

  // Unmapped addresses are always ready so the word is dropped on its valid
  // cycle; the ready depends on the address only, never on that writer's valid.
  always_comb begin
    w_wrrdy = '0;
    for (int i = 0; i < B_WRS; i++) begin
      w_wrrdy[i] = !w_mapped[i];
      for (int j = 0; j < B_RDS; j++)
        w_wrrdy[i] = w_wrrdy[i] | w_gnt[j][i];
    end
    if (rst) w_wrrdy = '0;
  end

  // Several unmapped writers in one cycle add together into a single pulse.
  always_comb begin
    w_nerr = 0;
    for (int i = 0; i < B_WRS; i++)
      if (bus.wrvlds[i] && !w_mapped[i]) w_nerr = w_nerr + 1;
    w_errsum = int'(r_errcnt) + w_nerr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errcnt <= '0;
      r_errvld <= 1'b0;
    end else begin
      r_errvld <= (w_nerr != 0);
      r_errcnt <= (w_errsum > ERRMAX) ? ERRW'(ERRMAX) : ERRW'(w_errsum);
    end
  end

  assign bus.wrrdys  = w_wrrdy;
  assign bus.rddatas = w_rddata;
  assign bus.rdaddrs = w_rdaddr;
  assign bus.rdvlds  = w_rdvld;
  assign bus.errcnt  = r_errcnt;
  assign bus.errvld  = r_errvld;
endmodule

// File: tb/tb_powlib_busxbar.sv
// Bench for powlib_busxbar: three instances (round robin ERRW=8, fixed priority
// ERRW=8, round robin ERRW=2) share one stimulus stream and are compared every
// cycle against a transaction-level model of windows, registers and pointers.
module tb_powlib_busxbar;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       s_wv = '0;
  logic [2:0][15:0] s_wa = '0;
  logic [2:0][31:0] s_wd = '0;
  logic [3:0]       s_rr = '0;

  powlib_busxbar_if #(.ERRW(8)) bus0 ();
  powlib_busxbar_if #(.ERRW(8)) bus1 ();
  powlib_busxbar_if #(.ERRW(2)) bus2 ();

  assign bus0.wrvlds = s_wv; assign bus0.wraddrs = s_wa; assign bus0.wrdatas = s_wd; assign bus0.rdrdys = s_rr;
  assign bus1.wrvlds = s_wv; assign bus1.wraddrs = s_wa; assign bus1.wrdatas = s_wd; assign bus1.rdrdys = s_rr;
  assign bus2.wrvlds = s_wv; assign bus2.wraddrs = s_wa; assign bus2.wrdatas = s_wd; assign bus2.rdrdys = s_rr;

  powlib_busxbar #(.ARB(1), .ERRW(8)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  powlib_busxbar #(.ARB(0), .ERRW(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  powlib_busxbar #(.ARB(1), .ERRW(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [3:0]   d_rdv[3];
  logic [127:0] d_rdd[3];
  logic [63:0]  d_rda[3];
  logic [2:0]   d_wrr[3];
  logic [7:0]   d_ec[3];
  logic         d_ev[3];
  assign d_rdv[0] = bus0.rdvlds; assign d_rdd[0] = bus0.rddatas; assign d_rda[0] = bus0.rdaddrs;
  assign d_wrr[0] = bus0.wrrdys; assign d_ec[0] = bus0.errcnt;   assign d_ev[0] = bus0.errvld;
  assign d_rdv[1] = bus1.rdvlds; assign d_rdd[1] = bus1.rddatas; assign d_rda[1] = bus1.rdaddrs;
  assign d_wrr[1] = bus1.wrrdys; assign d_ec[1] = bus1.errcnt;   assign d_ev[1] = bus1.errvld;
  assign d_rdv[2] = bus2.rdvlds; assign d_rdd[2] = bus2.rddatas; assign d_rda[2] = bus2.rdaddrs;
  assign d_wrr[2] = bus2.wrrdys; assign d_ec[2] = {6'b0, bus2.errcnt}; assign d_ev[2] = bus2.errvld;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr [3][4];
  bit          m_vld [3][4];
  logic [31:0] m_data[3][4];
  logic [15:0] m_addr[3][4];
  int          m_gnt [3][4];
  int          m_err [3];
  bit          m_ev  [3];
  int          ERRMAX[3] = '{255, 255, 3};
  int          IS_RR [3] = '{1, 0, 1};

  // Default windows: reader j covers [j*0x2000, j*0x2000+0x1FFF]; -1 = unmapped.
  function automatic int dec(input logic [15:0] a);
    int r = -1;
    for (int j = 0; j < 4; j++)
      if (int'(a) >= j * 32'h2000 && int'(a) - j * 32'h2000 <= 32'h1FFF) r = j;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_err[k] = 0; m_ev[k] = 0;
      for (int j = 0; j < 4; j++) begin
        m_ptr[k][j] = 2; m_vld[k][j] = 0; m_data[k][j] = '0; m_addr[k][j] = '0; m_gnt[k][j] = -1;
      end
    end
  endtask

  // Decide which writer each reader takes this cycle, and the expected readies.
  task automatic model_grant(input int k, output logic [2:0] rdy);
    int order[3];
    rdy = '0;
    for (int j = 0; j < 4; j++) begin
      m_gnt[k][j] = -1;
      for (int n = 0; n < 3; n++) order[n] = IS_RR[k] ? (m_ptr[k][j] + 1 + n) % 3 : n;
      if (!m_vld[k][j] || s_rr[j])
        foreach (order[n])
          if (m_gnt[k][j] < 0 && s_wv[order[n]] && dec(s_wa[order[n]]) == j) m_gnt[k][j] = order[n];
      if (m_gnt[k][j] >= 0) rdy[m_gnt[k][j]] = 1'b1;
    end
    for (int i = 0; i < 3; i++) if (dec(s_wa[i]) < 0) rdy[i] = 1'b1;
  endtask

  task automatic model_commit(input int k);
    int n = 0;
    for (int j = 0; j < 4; j++) begin
      if (m_gnt[k][j] >= 0) begin
        m_vld[k][j] = 1; m_data[k][j] = s_wd[m_gnt[k][j]]; m_addr[k][j] = s_wa[m_gnt[k][j]];
        m_ptr[k][j] = m_gnt[k][j];
      end else if (s_rr[j]) m_vld[k][j] = 0;
    end
    for (int i = 0; i < 3; i++) if (s_wv[i] && dec(s_wa[i]) < 0) n++;
    m_ev[k]  = (n > 0);
    m_err[k] = (m_err[k] + n > ERRMAX[k]) ? ERRMAX[k] : m_err[k] + n;
  endtask

  task automatic check_out(input int k);
    logic [3:0] ev; logic [127:0] ed; logic [63:0] ea;
    for (int j = 0; j < 4; j++) begin
      ev[j] = m_vld[k][j]; ed[j*32 +: 32] = m_data[k][j]; ea[j*16 +: 16] = m_addr[k][j];
    end
    chk($sformatf("i%0d rdvlds", k), 128'(d_rdv[k]), 128'(ev));
    chk($sformatf("i%0d rddatas", k), d_rdd[k], ed);
    chk($sformatf("i%0d rdaddrs", k), 128'(d_rda[k]), 128'(ea));
    chk($sformatf("i%0d errcnt", k), 128'(d_ec[k]), 128'(m_err[k]));
    chk($sformatf("i%0d errvld", k), 128'(d_ev[k]), 128'(m_ev[k]));
  endtask

  // One cycle: drive at negedge, check readies, clock, check registered outputs.
  task automatic step(input logic [2:0] wv, input logic [2:0][15:0] wa,
                      input logic [2:0][31:0] wd, input logic [3:0] rr);
    logic [2:0] rdy;
    s_wv = wv; s_wa = wa; s_wd = wd; s_rr = rr;
    #1;
    for (int k = 0; k < 3; k++) begin
      model_grant(k, rdy);
      chk($sformatf("i%0d wrrdys", k), 128'(d_wrr[k]), 128'(rdy));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_commit(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_out(k);
  endtask

  task automatic check_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("i%0d rst rdvlds", k), 128'(d_rdv[k]), 128'(0));
      chk($sformatf("i%0d rst wrrdys", k), 128'(d_wrr[k]), 128'(0));
      chk($sformatf("i%0d rst errcnt", k), 128'(d_ec[k]), 128'(0));
      chk($sformatf("i%0d rst errvld", k), 128'(d_ev[k]), 128'(0));
      chk($sformatf("i%0d rst rddatas", k), d_rdd[k], 128'(0));
      chk($sformatf("i%0d rst rdaddrs", k), 128'(d_rda[k]), 128'(0));
    end
    model_reset();
  endtask

  function automatic logic [15:0] rnd_addr();
    logic [15:0] edges[8] = '{16'h0000, 16'h1FFF, 16'h2000, 16'h3FFF, 16'h4000, 16'h5FFF, 16'h6000, 16'h7FFF};
    int m = $urandom_range(0, 9);
    if (m < 2) return 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
    if (m < 5) return edges[$urandom_range(0, 7)];
    if (m < 7) return 16'h0004;
    return 16'($urandom_range(0, 16'h7FFF));
  endfunction

  initial begin
    logic [2:0][15:0] wa;
    logic [2:0][31:0] wd;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_reset();
    rst = 1'b0;

    // single write to reader 1
    step(3'b001, {16'h0, 16'h0, 16'h2010}, {32'h0, 32'h0, 32'hA5A5A5A5}, 4'hF);
    chk("single rdvlds", 128'(d_rdv[0]), 128'(4'b0010));
    chk("single data", 128'(d_rdd[0][63:32]), 128'(32'hA5A5A5A5));
    chk("single addr", 128'(d_rda[0][31:16]), 128'(16'h2010));

    // contention on reader 0: round robin rotates, fixed priority sticks at 0
    for (int s = 0; s < 6; s++) begin
      step(3'b111, {3{16'h0004}}, {32'hC2, 32'hC1, 32'hC0}, 4'hF);
      chk("rr order", 128'(d_rdd[0][31:0]), 128'(32'hC0 + s % 3));
      chk("fp order", 128'(d_rdd[1][31:0]), 128'(32'hC0));
    end

    // backpressure on reader 2: first word held while rdrdys[2] low
    for (int s = 0; s < 5; s++) begin
      step(3'b010, {16'h0, 16'h4000, 16'h0}, {32'h0, 32'hBEEF0000 + 32'(s), 32'h0}, 4'b1011);
      chk("bp hold", 128'(d_rdd[0][95:64]), 128'(32'hBEEF0000));
    end
    step(3'b010, {16'h0, 16'h4000, 16'h0}, {32'h0, 32'hBEEF0005, 32'h0}, 4'hF);
    chk("bp release", 128'(d_rdd[0][95:64]), 128'(32'hBEEF0005));

    // two unmapped writers in one cycle, then saturation on the 2-bit counter
    step(3'b101, {3{16'h9000}}, '0, 4'hF);
    chk("unmap errcnt", 128'(d_ec[0]), 128'(2));
    chk("unmap errvld", 128'(d_ev[0]), 128'(1));
    step(3'b000, '0, '0, 4'hF);
    chk("unmap pulse end", 128'(d_ev[0]), 128'(0));
    step(3'b101, {3{16'h9000}}, '0, 4'hF);
    step(3'b101, {3{16'h9000}}, '0, 4'hF);
    chk("sat errcnt", 128'(d_ec[2]), 128'(3));
    chk("sat errvld", 128'(d_ev[2]), 128'(1));

    // randomized traffic
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < 3; i++) begin wa[i] = rnd_addr(); wd[i] = $urandom; end
      step(3'($urandom_range(0, 7)), wa, wd, 4'($urandom_range(0, 15) | $urandom_range(0, 15)));
    end

    // reset while reader 3 is stalled with a word
    step(3'b001, {16'h0, 16'h0, 16'h6000}, {32'h0, 32'h0, 32'h33}, 4'b0111);
    step(3'b000, '0, '0, 4'b0111);
    chk("pre-rst rdvld3", 128'(d_rdv[0][3]), 128'(1));
    rst = 1'b1;
    #1;
    check_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    step(3'b111, {3{16'h0004}}, {32'hE2, 32'hE1, 32'hE0}, 4'hF);
    chk("post-rst first", 128'(d_rdd[0][31:0]), 128'(32'hE0));
    chk("post-rst fp", 128'(d_rdd[1][31:0]), 128'(32'hE0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/powlib_busxbar.md
POWLIB_BUSXBAR -- requirements
Module: powlib_busxbar

Interface
REQ-001 SHALL have parameter B_WRS, default 3: number of writer ports.
REQ-002 SHALL have parameter B_RDS, default 4: number of reader ports.
REQ-003 SHALL have parameter B_AW, default 16: address width.
REQ-004 SHALL have parameter B_DW, default 32: data width.
REQ-005 SHALL have parameter B_BASES [B_RDS*B_AW], default {16'h6000,16'h4000,16'h2000,16'h0000}: reader j base at slice j.
REQ-006 SHALL have parameter B_SIZES [B_RDS*B_AW], default {4{16'h1FFF}}: reader j window size minus one.
REQ-007 SHALL have parameter ARB, default 1: 0 = fixed priority, 1 = round robin.
REQ-008 SHALL have parameter ERRW, default 8: error counter width.
REQ-009 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-010 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-011 SHALL have port wrdatas  in  B_WRS*B_DW  writer data, writer i at slice i.
REQ-012 SHALL have port wraddrs  in  B_WRS*B_AW  writer addresses.
REQ-013 SHALL have port wrvlds  in  B_WRS  writer valids.
REQ-014 SHALL have port wrrdys  out  B_WRS  writer readies.
REQ-015 SHALL have port rddatas  out  B_RDS*B_DW  reader data.
REQ-016 SHALL have port rdaddrs  out  B_RDS*B_AW  reader addresses, passed unmodified.
REQ-017 SHALL have port rdvlds  out  B_RDS  reader valids.
REQ-018 SHALL have port rdrdys  in  B_RDS  reader readies.
REQ-019 SHALL have port errcnt  out  ERRW  count of unmapped writes.
REQ-020 SHALL have port errvld  out  1  one-cycle pulse per unmapped write.

Function
REQ-021 SHALL decode writer i to reader j when addr>=base_j and (addr-base_j)<=size_j, in B_AW-bit unsigned arithmetic; highest matching j wins on overlap.
REQ-022 SHALL transfer a word on a cycle where wrvlds[i] and wrrdys[i] are both high; wrrdys never depends combinationally on wrvlds of the same writer except through arbitration.
REQ-023 SHALL hold one output register per reader; register j can load when !rdvlds[j] or rdrdys[j].
REQ-024 SHALL grant at most one writer per reader per cycle, only when register j can load; wrrdys[i] = granted.
REQ-025 SHALL, when ARB=0, grant the lowest requesting writer index.
REQ-026 SHALL, when ARB=1, grant the first requester at or after (ptr_j+1) mod B_WRS, wrapping; ptr_j updates to the granted index only on transfer.
REQ-027 SHALL present a granted word on rddatas/rdaddrs/rdvlds at the clock edge of acceptance (latency 1 cycle).
REQ-028 SHALL hold rddatas/rdaddrs stable while rdvlds[j] high and rdrdys[j] low.
REQ-029 SHALL sustain one word per cycle per reader when rdrdys held high; disjoint reader targets proceed in parallel.
REQ-030 SHALL, for an unmapped address, assert wrrdys[i] the same cycle, drop the word, pulse errvld the next cycle, increment errcnt.
REQ-031 SHALL saturate errcnt at 2^ERRW-1; errvld still pulses at saturation.
REQ-032 SHALL pulse errvld once per cycle even if several writers are unmapped in that cycle; errcnt adds the number of such writers, saturating.
REQ-033 SHALL not change ptr_j when a grant is withheld by backpressure.

Reset
REQ-034 SHALL, while rst high, force rdvlds=0, wrrdys=0, errvld=0, errcnt=0, all ptr_j=B_WRS-1 (writer 0 first), rddatas/rdaddrs=0.
REQ-035 SHALL discard any word in an output register when rst asserts mid-transfer; no word accepted during reset.
REQ-036 SHALL accept traffic from the first rising clk edge after rst deasserts.

Verification
REQ-037 Single write: writer 0 addr 0x2010 data 0xA5A5A5A5, rdrdys=all 1 -> rdvlds[1] high next edge with same addr/data; others low.
REQ-038 Round robin: ARB=1, writers 0,1,2 all to 0x0004 continuously, rdrdys[0]=1 -> rddatas[0] sources order 0,1,2,0,1,2; each wrrdys high one cycle in three.
REQ-039 Fixed priority: ARB=0, same stimulus -> writer 0 granted every cycle; writers 1,2 wrrdys stay 0.
REQ-040 Backpressure: rdrdys[2]=0 for 5 cycles, writer 1 to 0x4000 -> one word accepted, held stable 5 cycles, wrrdys[1]=0 until rdrdys[2] rises.
REQ-041 Unmapped: writers 0 and 2 to 0x9000 same cycle -> both wrrdys high, errvld one pulse, errcnt 0->2; ERRW=2 repeated -> errcnt sticks at 3.
REQ-042 Reset mid-operation: rst asserted while rdvlds[3]=1, rdrdys[3]=0 -> rdvlds[3]=0 immediately, errcnt=0; after release writer 0 granted first.
